// File: rtl/cnv_psum_quant.sv
// Requantises MAC partial sums: bias add, optional ReLU, rounding right shift and saturation.
// Results queue in a small FWFT FIFO that back-pressures the PE controller.
module cnv_psum_quant #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BLOCK_DEPTH = 32,
  parameter int unsigned PSUM_WIDTH  = 2 * DATA_WIDTH + $clog2(BLOCK_DEPTH * 3),
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH  = 4,
  localparam int unsigned CntWidth   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PECMAC_Sta,
  input  logic                   MACPEC_Fnh,
  input  logic [PSUM_WIDTH-1:0]  MACCNV_Mac,
  input  logic [PSUM_WIDTH-1:0]  CFG_Bias,
  input  logic [SHIFT_WIDTH-1:0] CFG_Shift,
  input  logic                   CFG_Relu,
  output logic [DATA_WIDTH-1:0]  CNVOUT_Dat,
  output logic                   CNVOUT_Vld,
  input  logic                   OUTCNV_Rdy,
  output logic                   CNVPEC_Full,
  output logic                   CNV_Ovf,
  output logic [CntWidth-1:0]    CNV_Cnt
);

  localparam int unsigned S1W  = PSUM_WIDTH + 1;
  localparam int unsigned S2W  = PSUM_WIDTH + 2;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic signed [S2W-1:0] SatMax = S2W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [S2W-1:0] SatMin = ~SatMax;

  // Capture control
  logic fnh_q, armed_q, armed_d, cap;

  assign cap     = armed_q & MACPEC_Fnh & ~fnh_q;
  assign armed_d = PECMAC_Sta | (armed_q & ~cap);

  always_ff @(posedge clk) begin
    if (rst) begin
      fnh_q   <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      fnh_q   <= MACPEC_Fnh;
      armed_q <= armed_d;
    end
  end

  // Pipeline stages
  logic                   s1_vld_q, s2_vld_q, s3_vld_q;
  logic signed [S1W-1:0]  s1_q, s1_d;
  logic [SHIFT_WIDTH-1:0] s1_shift_q;
  logic                   s1_relu_q;
  logic signed [S2W-1:0]  s2_q, s2_d, relu_val, half;
  logic [DATA_WIDTH-1:0]  s3_q, s3_d;

  always_comb begin
    s1_d = {MACCNV_Mac[PSUM_WIDTH-1], MACCNV_Mac} + {CFG_Bias[PSUM_WIDTH-1], CFG_Bias};
  end

  always_comb begin
    relu_val = (s1_relu_q && s1_q[S1W-1]) ? '0 : {s1_q[S1W-1], s1_q};
    half     = '0;
    if (s1_shift_q != '0) begin
      half = {{(S2W-1){1'b0}}, 1'b1} << (s1_shift_q - 1'b1);
    end
    // Shifts beyond the operand range round to exactly zero; skip the unrepresentable half.
    if (32'(s1_shift_q) > S1W) begin
      s2_d = '0;
    end else begin
      s2_d = (relu_val + half) >>> s1_shift_q;
    end
  end

  always_comb begin
    if (s2_q > SatMax) begin
      s3_d = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (s2_q < SatMin) begin
      s3_d = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      s3_d = s2_q[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s3_vld_q   <= 1'b0;
      s1_q       <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      s2_q       <= '0;
      s3_q       <= '0;
    end else begin
      s1_vld_q <= cap;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      if (cap) begin
        s1_q       <= s1_d;
        s1_shift_q <= CFG_Shift;
        s1_relu_q  <= CFG_Relu;
      end
      if (s1_vld_q) s2_q <= s2_d;
      if (s2_vld_q) s3_q <= s3_d;
    end
  end

  // Output FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  ovf_q, fifo_full, pop, push_ok, drop;

  assign fifo_full = (cnt_q == CntWidth'(FIFO_DEPTH));
  assign CNVOUT_Vld = (cnt_q != '0);
  assign pop       = CNVOUT_Vld & OUTCNV_Rdy;
  // A simultaneous pop frees the slot, so a push to a full FIFO is still accepted.
  assign push_ok   = s3_vld_q & (~fifo_full | pop);
  assign drop      = s3_vld_q & fifo_full & ~pop;
  assign cnt_d     = cnt_q + CntWidth'(push_ok) - CntWidth'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop)     rptr_q <= rptr_q + PtrW'(1);
      if (drop)    ovf_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= s3_q;
  end

  assign CNVOUT_Dat  = CNVOUT_Vld ? mem_q[rptr_q] : '0;
  assign CNV_Cnt     = cnt_q;
  assign CNV_Ovf     = ovf_q;
  assign CNVPEC_Full = ({1'b0, cnt_q} + (CntWidth+1)'(s1_vld_q) + (CntWidth+1)'(s2_vld_q)
                        + (CntWidth+1)'(s3_vld_q)) >= (CntWidth+1)'(FIFO_DEPTH);

endmodule

// File: tb/tb_cnv_psum_quant.sv
// Scoreboard bench for cnv_psum_quant: directed corner cases plus randomized jobs
// checked against an integer reference model.
module tb_cnv_psum_quant;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 23;
  localparam int unsigned SW = 5;
  localparam int unsigned CW = 3;
  localparam longint MaxV = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint MinV = -(64'sd1 <<< (DW - 1));

  logic          clk, rst;
  logic          PECMAC_Sta, MACPEC_Fnh;
  logic [PW-1:0] MACCNV_Mac, CFG_Bias;
  logic [SW-1:0] CFG_Shift;
  logic          CFG_Relu;
  logic [DW-1:0] CNVOUT_Dat;
  logic          CNVOUT_Vld, OUTCNV_Rdy, CNVPEC_Full, CNV_Ovf;
  logic [CW-1:0] CNV_Cnt;

  int vectors = 0;
  int miscompares = 0;
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random
  bit rnd_rdy = 0;
  logic [DW-1:0] exp_q[$];

  cnv_psum_quant dut (
    .clk         (clk),
    .rst         (rst),
    .PECMAC_Sta  (PECMAC_Sta),
    .MACPEC_Fnh  (MACPEC_Fnh),
    .MACCNV_Mac  (MACCNV_Mac),
    .CFG_Bias    (CFG_Bias),
    .CFG_Shift   (CFG_Shift),
    .CFG_Relu    (CFG_Relu),
    .CNVOUT_Dat  (CNVOUT_Dat),
    .CNVOUT_Vld  (CNVOUT_Vld),
    .OUTCNV_Rdy  (OUTCNV_Rdy),
    .CNVPEC_Full (CNVPEC_Full),
    .CNV_Ovf     (CNV_Ovf),
    .CNV_Cnt     (CNV_Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end
  assign OUTCNV_Rdy = (rdy_mode == 2) ? rnd_rdy : (rdy_mode == 1);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference: exact integer arithmetic with floor division for the rounding shift.
  function automatic logic [DW-1:0] model(input longint mac, input longint bias,
                                          input int shift, input bit relu);
    longint s, half, q;
    s = mac + bias;
    if (relu && s < 0) s = 0;
    half = (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 1));
    q = (s + half) >>> shift;
    if (q > MaxV) q = MaxV;
    if (q < MinV) q = MinV;
    return q[DW-1:0];
  endfunction

  // Monitor: every accepted head entry is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && CNVOUT_Vld && OUTCNV_Rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(CNVOUT_Dat), 32'hFFFF_FFFF);
      end else begin
        check("sb_data", 32'(CNVOUT_Dat), 32'(exp_q.pop_front()));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the capture edge.
  task automatic job(input longint mac, input longint bias, input int shift, input bit relu,
                     input int low);
    PECMAC_Sta = 1'b1;
    MACPEC_Fnh = 1'b0;
    @(posedge clk); #1;
    PECMAC_Sta = 1'b0;
    repeat (low - 1) begin @(posedge clk); #1; end
    MACPEC_Fnh = 1'b1;
    MACCNV_Mac = PW'(mac);
    CFG_Bias   = PW'(bias);
    CFG_Shift  = SW'(shift);
    CFG_Relu   = relu;
    @(posedge clk); #1;
    MACCNV_Mac = PW'($urandom);
    CFG_Bias   = PW'($urandom);
    CFG_Shift  = SW'($urandom);
    CFG_Relu   = 1'($urandom);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      cycles(1);
      guard++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    cycles(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    logic signed [PW-1:0] rm, rb;
    int rs, guard;
    bit rr;
    rst = 1'b1; PECMAC_Sta = 1'b0; MACPEC_Fnh = 1'b1;
    MACCNV_Mac = '0; CFG_Bias = '0; CFG_Shift = '0; CFG_Relu = 1'b0;
    cycles(2);
    rst = 1'b0;

    check("rst_dat", 32'(CNVOUT_Dat), 0);
    check("rst_vld", 32'(CNVOUT_Vld), 0);
    check("rst_full", 32'(CNVPEC_Full), 0);
    check("rst_ovf", 32'(CNV_Ovf), 0);
    check("rst_cnt", 32'(CNV_Cnt), 0);

    cycles(20);
    check("idle_vld", 32'(CNVOUT_Vld), 0);
    check("idle_cnt", 32'(CNV_Cnt), 0);
    MACPEC_Fnh = 1'b0; cycles(3); MACPEC_Fnh = 1'b1; cycles(6);
    check("unarmed_edge_vld", 32'(CNVOUT_Vld), 0);

    // Latency and saturation
    rdy_mode = 0;
    job(1000, 24, 3, 1'b1, 5);
    exp_q.push_back(8'd127);
    cycles(1); check("lat_e1_vld", 32'(CNVOUT_Vld), 0);
    cycles(1); check("lat_e2_vld", 32'(CNVOUT_Vld), 0);
    cycles(1); check("lat_e3_vld", 32'(CNVOUT_Vld), 1);
    check("lat_e3_cnt", 32'(CNV_Cnt), 1);
    cycles(2); check("hold_dat", 32'(CNVOUT_Dat), 32'd127);
    rdy_mode = 1;
    drain();
    check("empty_dat", 32'(CNVOUT_Dat), 0);

    job(-100, 0, 2, 1'b1, 2); exp_q.push_back(8'd0);
    job(-100, 0, 2, 1'b0, 2); exp_q.push_back(8'hE7);
    job(37, 0, 1, 1'b0, 2);   exp_q.push_back(8'd19);
    drain();

    // Overflow: five back-to-back jobs with the consumer stalled
    rdy_mode = 0;
    for (int i = 1; i <= 5; i++) begin
      job(10 * i, 0, 0, 1'b0, 1);
      if (i <= 4) exp_q.push_back(8'(10 * i));
      if (i == 3) check("full_at_3", 32'(CNVPEC_Full), 0);
      if (i == 4) check("full_at_4", 32'(CNVPEC_Full), 1);
    end
    cycles(4);
    check("ovf_cnt", 32'(CNV_Cnt), 4);
    check("ovf_flag", 32'(CNV_Ovf), 1);
    check("ovf_full", 32'(CNVPEC_Full), 1);
    check("ovf_head", 32'(CNVOUT_Dat), 32'd10);
    rdy_mode = 1;
    drain();
    check("ovf_sticky", 32'(CNV_Ovf), 1);
    check("drained_cnt", 32'(CNV_Cnt), 0);

    // Reset one cycle after a capture discards the in-flight result
    rdy_mode = 0;
    job(5, 0, 0, 1'b0, 2);
    do_reset();
    check("mid_rst_vld", 32'(CNVOUT_Vld), 0);
    check("mid_rst_cnt", 32'(CNV_Cnt), 0);
    check("mid_rst_ovf", 32'(CNV_Ovf), 0);
    check("mid_rst_full", 32'(CNVPEC_Full), 0);
    rdy_mode = 1;
    cycles(6);
    check("no_stale_vld", 32'(CNVOUT_Vld), 0);

    // Push arriving at a full FIFO while the head is popped
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      job(-3 - i, 0, 0, 1'b0, 1);
      exp_q.push_back(8'(-3 - i));
    end
    guard = 0;
    while (CNV_Cnt != 3'd4 && guard < 20) begin cycles(1); guard++; end
    check("fill_cnt", 32'(CNV_Cnt), 4);
    job(77, 0, 0, 1'b0, 2);
    exp_q.push_back(8'd77);
    cycles(2);
    rdy_mode = 1;
    cycles(1);
    check("pushpop_cnt", 32'(CNV_Cnt), 4);
    check("pushpop_ovf", 32'(CNV_Ovf), 0);
    drain();

    // Randomized jobs honouring back-pressure
    rdy_mode = 2;
    for (int n = 0; n < 60; n++) begin
      guard = 0;
      while (CNVPEC_Full && guard < 50) begin cycles(1); guard++; end
      if (guard >= 50) check("full_timeout", 32'(CNVPEC_Full), 0);
      rm = PW'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? PW'($urandom) : PW'($signed($urandom_range(0, 2000)) - 1000);
      rs = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PW + 1) : $urandom_range(10, 20);
      rr = 1'($urandom_range(0, 1));
      job(longint'(rm), longint'(rb), rs, rr, $urandom_range(1, 4));
      exp_q.push_back(model(longint'(rm), longint'(rb), rs, rr));
    end
    drain();
    check("rand_ovf", 32'(CNV_Ovf), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cnv_psum_quant.md
Name: cnv_psum_quant

Overview:
- Downstream neighbour of the MAC array lane.
- Captures each finished MAC partial sum (MACCNV_Mac) when MACPEC_Fnh rises after a start.
- Adds a per-channel bias, applies optional ReLU, a round-half-up arithmetic right shift and saturation to DATA_WIDTH.
- Buffers the resulting activations in a small first-word-fall-through FIFO with a valid/ready output, and back-pressures the PE controller.

Parameters:
- DATA_WIDTH, 8: activation/weight width; also the output width.
- BLOCK_DEPTH, 32: MAC block depth.
- PSUM_WIDTH, 2*DATA_WIDTH+C_LOG_2(BLOCK_DEPTH*3) (=23): MAC result width.
- SHIFT_WIDTH, 5: width of the requantisation shift amount.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- PECMAC_Sta  in  1  start pulse to the MAC; arms a capture.
- MACPEC_Fnh  in  1  MAC finish level; resets high, low while computing.
- MACCNV_Mac  in  PSUM_WIDTH  signed MAC result.
- CFG_Bias  in  PSUM_WIDTH  signed bias.
- CFG_Shift  in  SHIFT_WIDTH  right-shift amount.
- CFG_Relu  in  1  1 = clamp negatives to 0.
- CNVOUT_Dat  out  DATA_WIDTH  signed quantised result (FIFO head).
- CNVOUT_Vld  out  1  FIFO non-empty.
- OUTCNV_Rdy  in  1  consumer accepts the head entry.
- CNVPEC_Full  out  1  PE controller must not issue PECMAC_Sta.
- CNV_Ovf  out  1  sticky: a result was dropped.
- CNV_Cnt  out  C_LOG_2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge): armed=0, Fnh_d=1, all pipeline valids=0, FIFO empty.
  - Outputs after reset: CNVOUT_Dat=0, CNVOUT_Vld=0, CNVPEC_Full=0, CNV_Ovf=0, CNV_Cnt=0.
  - Applies identically mid-operation: in-flight and buffered results are discarded.
- Fnh_d is MACPEC_Fnh registered each cycle.
- cap = armed & MACPEC_Fnh & ~Fnh_d. This is a rising edge seen after a start, so the reset-high Fnh never captures.
- armed update:
  - set on PECMAC_Sta;
  - cleared on cap;
  - if PECMAC_Sta and cap occur in the same cycle, the capture happens and armed stays 1.
- Stage S1, at the edge where cap=1:
  - s1 = sext(MACCNV_Mac) + sext(CFG_Bias), PSUM_WIDTH+1 bits;
  - CFG_Shift and CFG_Relu are latched alongside s1 and travel with the data.
- Stage S2, next edge:
  - r = (relu & s1<0) ? 0 : s1;
  - s2 = (r + (shift==0 ? 0 : 1<<(shift-1))) >>> shift, with PSUM_WIDTH+2 bits and arithmetic shift.
- Stage S3, next edge: sat = clamp(s2, -2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1), pushed into the FIFO.
- Latency: data sampled at edge E0 (cap) appears on CNVOUT_Dat with CNVOUT_Vld=1 after edge E3 when the FIFO was empty. One result per cycle is sustainable.
- Pop: at a clock edge where CNVOUT_Vld & OUTCNV_Rdy, the head advances.
- Push and pop in the same cycle:
  - legal even when the FIFO is full;
  - CNV_Cnt is unchanged and the new entry is accepted.
- Push to a full FIFO without a pop:
  - the entry is dropped and CNV_Ovf becomes 1;
  - CNV_Ovf stays 1 until reset.
- Read/write pointers wrap modulo FIFO_DEPTH; CNV_Cnt ranges 0..FIFO_DEPTH.
- CNVPEC_Full = (CNV_Cnt + number of valid S1/S2/S3 entries) >= FIFO_DEPTH. This is combinational from registers.
- CNVOUT_Dat holds the head entry while CNVOUT_Vld=1 and OUTCNV_Rdy=0; it is 0 when the FIFO is empty.
- Config inputs outside the capture cycle are don't-care.

Test Plan:
- Reset, then hold MACPEC_Fnh=1 with no PECMAC_Sta for 20 cycles -> no capture, CNVOUT_Vld=0, CNV_Cnt=0.
- Sta, then Fnh low for 5 cycles and high; Mac=1000, Bias=24, Shift=3, Relu=1 -> (1024+4)>>>3=128 saturates to CNVOUT_Dat=127, Vld 3 cycles after cap.
- Mac=-100, Bias=0: with Relu=1, Shift=2 -> Dat=0; with Relu=0, Shift=2 -> (-100+2)>>>2 = -25 (0xE7); with Mac=37, Shift=1, Relu=0 -> 19.
- Rdy=0 and 5 back-to-back jobs -> CNVPEC_Full=1 once 4 are in flight or buffered; 5th result dropped; CNV_Ovf=1; CNV_Cnt=4; first 4 values then pop in order.
- FIFO full with Rdy=1 and a push arriving the same cycle -> CNV_Cnt stays 4, CNV_Ovf stays 0, no data lost.
- Assert rst one cycle after cap -> next cycle Vld=0, Cnt=0, Ovf=0; no stale result is ever emitted.
